imem_arbiter: RTL
=================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, meaning word-aligned byte-address width of the shared instruction memory.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 f_req_i  input  1  fetch read request.
REQ-005 f_addr_i  input  32  fetch byte address.
REQ-006 f_gnt_o  output  1  fetch request accepted this cycle.
REQ-007 f_rvalid_o  output  1  fetch read data valid.
REQ-008 f_rdata_o  output  32  fetch read data.
REQ-009 f_err_o  output  1  qualifies f_rvalid_o; address out of range.
REQ-010 l_req_i  input  1  loader/debug request.
REQ-011 l_we_i  input  1  loader write (1) or read (0).
REQ-012 l_addr_i  input  32  loader byte address.
REQ-013 l_wdata_i  input  32  loader write data.
REQ-014 l_gnt_o  output  1  loader request accepted this cycle.
REQ-015 l_rvalid_o  output  1  loader read data valid / write acknowledge.
REQ-016 l_rdata_o  output  32  loader read data.
REQ-017 l_boot_done_i  input  1  single-cycle pulse: program image loaded.
REQ-018 fetch_hold_o  output  1  stall request to fetch stage.
REQ-019 mem_en_o, mem_we_o  output  1 each  memory enable, write enable.
REQ-020 mem_addr_o  output  ADDR_W  memory byte address; mem_wdata_o output 32; mem_rdata_i input 32, one-cycle synchronous read latency.

Function
REQ-021 FSM states BOOT and RUN; BOOT -> RUN on l_boot_done_i; RUN -> BOOT only via reset.
REQ-022 BOOT: only loader may be granted; f_gnt_o=0; fetch_hold_o=1.
REQ-023 RUN: fetch_hold_o=1 in any cycle f_req_i=1 and f_gnt_o=0, else 0.
REQ-024 Grants combinational, same cycle as request; at most one of f_gnt_o/l_gnt_o high per cycle.
REQ-025 Granted access drives mem_en_o=1, mem_addr_o=addr[ADDR_W-1:0] with addr[1:0] forced to 0; mem_we_o=l_we_i only for loader grants; no grant -> mem_en_o=0.
REQ-026 Out-of-range access (any addr bit at or above ADDR_W set): granted, mem_en_o=0; response next cycle with rdata=32'h00000013, err flag 1 (fetch) or write dropped (loader).
REQ-027 Response exactly one cycle after grant on owner's rvalid; owner held in a registered tag; non-owner's rvalid stays 0.
REQ-028 Loader write: l_rvalid_o pulses next cycle with l_rdata_o=0.
REQ-029 rdata outputs driven from mem_rdata_i only while the matching rvalid=1, else 0.
REQ-030 l_boot_done_i while a loader access is in flight: state change next edge; in-flight response still delivered.
REQ-031 Back-to-back grants every cycle allowed; throughput one access per cycle.

Reset
REQ-032 Reset: state=BOOT, all gnt/rvalid/err=0, rdata=0, mem_en_o=0, mem_we_o=0, fetch_hold_o=1, owner tag cleared, round-robin pointer = loader-last.
REQ-033 Reset mid-access: pending response discarded; no rvalid after deassertion.

Configuration
REQ-034 Macro IMEM_ARB_RR_EN defined: RUN-state contention resolved round-robin (grant requester not granted most recently; pointer updates on every grant).
REQ-035 Macro undefined: RUN-state contention resolved fixed-priority, loader wins; pointer logic absent.

Verification
REQ-036 Reset, no boot_done, f_req_i=1 for 10 cycles -> f_gnt_o=0, fetch_hold_o=1 throughout.
REQ-037 BOOT: loader write 0xDEADBEEF @0x10, boot_done, fetch @0x10 -> l_rvalid_o next cycle, then f_rvalid_o with f_rdata_o=0xDEADBEEF one cycle after f_gnt_o.
REQ-038 RUN, both requesting 4 cycles -> with IMEM_ARB_RR_EN grants F,L,F,L; without, L,L,L,L with fetch_hold_o=1.
REQ-039 Fetch @0x00000800 (ADDR_W=11) -> mem_en_o=0, next cycle f_rvalid_o=1, f_err_o=1, f_rdata_o=0x00000013.
REQ-040 Assert rst_i in cycle after fetch grant -> no f_rvalid_o, state BOOT, fetch_hold_o=1.

Source files
------------

// File: rtl/imem_arbiter.sv
// Two-port arbiter (fetch / loader) for one shared single-port instruction memory.
// Define IMEM_ARB_RR_EN for round-robin RUN-state arbitration; default is loader-priority.
module imem_arbiter #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              f_req_i,
  input  logic [31:0]       f_addr_i,
  output logic              f_gnt_o,
  output logic              f_rvalid_o,
  output logic [31:0]       f_rdata_o,
  output logic              f_err_o,
  input  logic              l_req_i,
  input  logic              l_we_i,
  input  logic [31:0]       l_addr_i,
  input  logic [31:0]       l_wdata_i,
  output logic              l_gnt_o,
  output logic              l_rvalid_o,
  output logic [31:0]       l_rdata_o,
  input  logic              l_boot_done_i,
  output logic              fetch_hold_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e state_q, state_d;
  logic   rsp_f_q, rsp_f_d;
  logic   rsp_l_q, rsp_l_d;
  logic   rsp_oor_q, rsp_oor_d;
  logic   rsp_we_q, rsp_we_d;
`ifdef IMEM_ARB_RR_EN
  logic   last_l_q, last_l_d;
`endif

  logic f_oor, l_oor;
  logic f_gnt, l_gnt;

  assign f_oor = (f_addr_i >> ADDR_W) != 32'd0;
  assign l_oor = (l_addr_i >> ADDR_W) != 32'd0;

  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst_i) begin
      f_gnt = 1'b0;
    end else if (state_q == StBoot) begin
      l_gnt = l_req_i;
    end else if (f_req_i && l_req_i) begin
`ifdef IMEM_ARB_RR_EN
      // Grant whoever was not granted most recently.
      if (last_l_q) f_gnt = 1'b1;
      else          l_gnt = 1'b1;
`else
      l_gnt = 1'b1;
`endif
    end else begin
      f_gnt = f_req_i;
      l_gnt = l_req_i;
    end
  end

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (f_gnt) begin
      mem_en_o   = ~f_oor;
      mem_addr_o = {f_addr_i[ADDR_W-1:2], 2'b00};
    end else if (l_gnt) begin
      mem_en_o    = ~l_oor;
      mem_we_o    = l_we_i & ~l_oor;
      mem_addr_o  = {l_addr_i[ADDR_W-1:2], 2'b00};
      mem_wdata_o = l_wdata_i;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == StBoot && l_boot_done_i) state_d = StRun;
    rsp_f_d   = f_gnt;
    rsp_l_d   = l_gnt;
    rsp_oor_d = f_gnt ? f_oor : (l_gnt & l_oor);
    rsp_we_d  = l_gnt & l_we_i;
`ifdef IMEM_ARB_RR_EN
    last_l_d = last_l_q;
    if (f_gnt) last_l_d = 1'b0;
    if (l_gnt) last_l_d = 1'b1;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StBoot;
      rsp_f_q   <= 1'b0;
      rsp_l_q   <= 1'b0;
      rsp_oor_q <= 1'b0;
      rsp_we_q  <= 1'b0;
`ifdef IMEM_ARB_RR_EN
      last_l_q  <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      rsp_f_q   <= rsp_f_d;
      rsp_l_q   <= rsp_l_d;
      rsp_oor_q <= rsp_oor_d;
      rsp_we_q  <= rsp_we_d;
`ifdef IMEM_ARB_RR_EN
      last_l_q  <= last_l_d;
`endif
    end
  end

  always_comb begin
    f_gnt_o      = f_gnt;
    l_gnt_o      = l_gnt;
    fetch_hold_o = (state_q == StBoot) | (f_req_i & ~f_gnt);
    f_rvalid_o   = rsp_f_q;
    f_err_o      = rsp_f_q & rsp_oor_q;
    f_rdata_o    = '0;
    if (rsp_f_q) f_rdata_o = rsp_oor_q ? NopInstr : mem_rdata_i;
    l_rvalid_o   = rsp_l_q;
    l_rdata_o    = '0;
    // Write acks return zero data, including dropped out-of-range writes.
    if (rsp_l_q && !rsp_we_q) l_rdata_o = rsp_oor_q ? NopInstr : mem_rdata_i;
  end

endmodule
